// File: rtl/knn_vote.sv
// knn_vote: majority vote over a sorted K-nearest-neighbour list.
// A list is captured into a private buffer, then one entry per cycle is
// scored (its label's vote count across all non-empty entries) and compared
// against the running best one cycle later. The first (nearest) entry
// reaching the highest vote count wins. Empty entries carry an all-ones
// distance and never vote or win.
module knn_vote #(
    parameter int DATA_W      = 32,
    parameter int LABEL_W     = 8,
    parameter int N_NEIGHBOUR = 4
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [(DATA_W+LABEL_W)*N_NEIGHBOUR-1:0] neighbour_info,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [LABEL_W-1:0]                      out_label,
    output logic [$clog2(N_NEIGHBOUR+1)-1:0]        out_votes,
    output logic [DATA_W-1:0]                       out_dist,
    output logic                                    out_none
);

    localparam int ENTRY_W = DATA_W + LABEL_W;
    localparam int LIST_W  = ENTRY_W * N_NEIGHBOUR;
    localparam int VOTE_W  = $clog2(N_NEIGHBOUR + 1);
    // The index runs 0..K; the extra value K is the final compare-only cycle.
    localparam int IDX_W   = VOTE_W;

    localparam logic [DATA_W-1:0]  EMPTY_DIST = {DATA_W{1'b1}};
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N_NEIGHBOUR);
    localparam logic [IDX_W-1:0]   IDX_ZERO   = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);
    localparam logic [VOTE_W-1:0]  VOTE_ZERO  = {VOTE_W{1'b0}};
    localparam logic [LABEL_W-1:0] LABEL_ZERO = {LABEL_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;

    logic [LIST_W-1:0]   buf_r;
    logic [IDX_W-1:0]    idx_r;

    // Candidate stage: scored entry waiting for comparison.
    logic                cand_v_r;
    logic [VOTE_W-1:0]   cand_votes_r;
    logic [LABEL_W-1:0]  cand_label_r;
    logic [DATA_W-1:0]   cand_dist_r;

    // Running best.
    logic [VOTE_W-1:0]   best_votes_r;
    logic [LABEL_W-1:0]  best_label_r;
    logic [DATA_W-1:0]   best_dist_r;

    // Registered outputs.
    logic                in_ready_r;
    logic                out_valid_r;
    logic [LABEL_W-1:0]  out_label_r;
    logic [VOTE_W-1:0]   out_votes_r;
    logic [DATA_W-1:0]   out_dist_r;
    logic                out_none_r;

    logic [LABEL_W-1:0]  lab_s [N_NEIGHBOUR];
    logic [DATA_W-1:0]   dst_s [N_NEIGHBOUR];
    logic [LABEL_W-1:0]  sel_label_s;
    logic [DATA_W-1:0]   sel_dist_s;
    logic [VOTE_W-1:0]   sel_votes_s;
    logic                sel_scorable_s;
    logic                take_s;
    logic [VOTE_W-1:0]   best_votes_s;
    logic [LABEL_W-1:0]  best_label_s;
    logic [DATA_W-1:0]   best_dist_s;
    logic                accept_s;
    logic                in_ready_s;
    logic                load_out_s;
    logic                release_s;

    // Split the buffered list into per-entry label and distance fields.
    always_comb begin
        for (int j = 0; j < N_NEIGHBOUR; j++) begin
            lab_s[j] = buf_r[j*ENTRY_W +: LABEL_W];
            dst_s[j] = buf_r[j*ENTRY_W + LABEL_W +: DATA_W];
        end
    end

    // Select entry idx_r (AND-OR mux) and count the votes for its label.
    always_comb begin
        sel_label_s = LABEL_ZERO;
        sel_dist_s  = {DATA_W{1'b0}};
        sel_votes_s = VOTE_ZERO;
        for (int j = 0; j < N_NEIGHBOUR; j++) begin
            sel_label_s = sel_label_s | (lab_s[j] & {LABEL_W{idx_r == IDX_W'(j)}});
            sel_dist_s  = sel_dist_s  | (dst_s[j] & {DATA_W{idx_r == IDX_W'(j)}});
        end
        for (int j = 0; j < N_NEIGHBOUR; j++) begin
            sel_votes_s = sel_votes_s +
                VOTE_W'((dst_s[j] != EMPTY_DIST) && (lab_s[j] == sel_label_s));
        end
        sel_scorable_s = (idx_r != LAST_IDX) && (sel_dist_s != EMPTY_DIST);
    end

    // Strictly-greater compare keeps the nearest candidate on a tie.
    always_comb begin
        take_s       = cand_v_r && (cand_votes_r > best_votes_r);
        best_votes_s = take_s ? cand_votes_r : best_votes_r;
        best_label_s = take_s ? cand_label_r : best_label_r;
        best_dist_s  = take_s ? cand_dist_r  : best_dist_r;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    state_s = COUNT;
                end else begin
                    state_s = IDLE;
                end
            end
            COUNT: begin
                if (idx_r == LAST_IDX) begin
                    state_s = DONE;
                end else begin
                    state_s = COUNT;
                end
            end
            DONE: begin
                if (out_valid_r && out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM output decode: control strobes for datapath and output registers.
    always_comb begin
        accept_s   = (state_r == IDLE) && in_valid && in_ready_r;
        in_ready_s = (state_s == IDLE);
        load_out_s = (state_r == COUNT) && (state_s == DONE);
        release_s  = (state_r == DONE) && (state_s == IDLE);
    end

    // Datapath: capture list, step index, score candidate, track best.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_r        <= {LIST_W{1'b0}};
            idx_r        <= IDX_ZERO;
            cand_v_r     <= 1'b0;
            cand_votes_r <= VOTE_ZERO;
            cand_label_r <= LABEL_ZERO;
            cand_dist_r  <= {DATA_W{1'b0}};
            best_votes_r <= VOTE_ZERO;
            best_label_r <= LABEL_ZERO;
            best_dist_r  <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            buf_r        <= neighbour_info;
            idx_r        <= IDX_ZERO;
            cand_v_r     <= 1'b0;
            best_votes_r <= VOTE_ZERO;
            best_label_r <= LABEL_ZERO;
            best_dist_r  <= EMPTY_DIST;
        end else if (state_r == COUNT) begin
            idx_r        <= (idx_r == LAST_IDX) ? idx_r : idx_r + IDX_ONE;
            cand_v_r     <= sel_scorable_s;
            cand_votes_r <= sel_votes_s;
            cand_label_r <= sel_label_s;
            cand_dist_r  <= sel_dist_s;
            best_votes_r <= best_votes_s;
            best_label_r <= best_label_s;
            best_dist_r  <= best_dist_s;
        end
    end

    // Output registers: load the final result on entering DONE, hold it
    // until the handshake; in_ready follows the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_label_r <= LABEL_ZERO;
            out_votes_r <= VOTE_ZERO;
            out_dist_r  <= {DATA_W{1'b0}};
            out_none_r  <= 1'b0;
        end else begin
            in_ready_r <= in_ready_s;
            if (load_out_s) begin
                out_valid_r <= 1'b1;
                out_label_r <= best_label_s;
                out_votes_r <= best_votes_s;
                out_dist_r  <= best_dist_s;
                out_none_r  <= (best_votes_s == VOTE_ZERO);
            end else if (release_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_label = out_label_r;
    assign out_votes = out_votes_r;
    assign out_dist  = out_dist_r;
    assign out_none  = out_none_r;

endmodule

// File: tb/tb_knn_vote.sv
// Directed bench for knn_vote (K=4, DATA_W=32, LABEL_W=8) with a
// histogram-based reference model and a per-cycle output comparator.
module tb_knn_vote;

    localparam int K  = 4;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int VW = 3;

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [(DW+LW)*K-1:0]  neighbour_info;
    logic                  out_valid;
    logic                  out_ready;
    logic [LW-1:0]         out_label;
    logic [VW-1:0]         out_votes;
    logic [DW-1:0]         out_dist;
    logic                  out_none;

    int n_vec  = 0;
    int n_miss = 0;

    logic          armed = 1'b0;
    logic [LW-1:0] exp_label;
    logic [VW-1:0] exp_votes;
    logic [DW-1:0] exp_dist;
    logic          exp_none;

    logic [K-1:0][LW-1:0] labs;
    logic [K-1:0][DW-1:0] dsts;

    knn_vote #(.DATA_W(DW), .LABEL_W(LW), .N_NEIGHBOUR(K)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .neighbour_info (neighbour_info),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_label      (out_label),
        .out_votes      (out_votes),
        .out_dist       (out_dist),
        .out_none       (out_none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [(DW+LW)*K-1:0] pack(input logic [K-1:0][LW-1:0] l,
                                                  input logic [K-1:0][DW-1:0] d);
        logic [(DW+LW)*K-1:0] r;
        r = '0;
        for (int i = 0; i < K; i++) r[i*(DW+LW) +: (DW+LW)] = {d[i], l[i]};
        return r;
    endfunction

    // Reference: histogram the labels of non-empty entries, find the top
    // count, winner is the nearest non-empty entry whose label has that count.
    task automatic model(input logic [K-1:0][LW-1:0] l, input logic [K-1:0][DW-1:0] d);
        int  hist [256];
        int  maxv;
        bit  found;
        for (int v = 0; v < 256; v++) hist[v] = 0;
        for (int i = 0; i < K; i++)
            if (d[i] != 32'hFFFF_FFFF) hist[l[i]] = hist[l[i]] + 1;
        maxv = 0;
        for (int v = 0; v < 256; v++) if (hist[v] > maxv) maxv = hist[v];
        exp_label = 8'd0;
        exp_votes = 3'd0;
        exp_dist  = 32'hFFFF_FFFF;
        exp_none  = (maxv == 0);
        found = 1'b0;
        for (int i = 0; i < K; i++) begin
            if (!found && d[i] != 32'hFFFF_FFFF && hist[l[i]] == maxv) begin
                found     = 1'b1;
                exp_label = l[i];
                exp_votes = VW'(maxv);
                exp_dist  = d[i];
            end
        end
    endtask

    // Per-cycle comparator: whenever a result is presented it must match the model.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            check("unexpected_valid", {63'd0, armed}, 64'd1);
            check("cyc_label", {56'd0, out_label}, {56'd0, exp_label});
            check("cyc_votes", {61'd0, out_votes}, {61'd0, exp_votes});
            check("cyc_dist",  {32'd0, out_dist},  {32'd0, exp_dist});
            check("cyc_none",  {63'd0, out_none},  {63'd0, exp_none});
        end
    end

    // Present labs/dsts and return #1 after the accepting edge.
    task automatic accept_list();
        int t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1; t++;
        end
        check("in_ready_wait", {63'd0, in_ready}, 64'd1);
        neighbour_info = pack(labs, dsts);
        model(labs, dsts);
        armed    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid       = 1'b0;
        neighbour_info = {$urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    // Wait (bounded) for out_valid and check the K+1 latency.
    task automatic wait_result();
        int lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("latency", lat, K + 1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        armed     = 1'b0;
        check("hs_out_valid", {63'd0, out_valid}, 64'd0);
        check("hs_in_ready",  {63'd0, in_ready},  64'd1);
    endtask

    task automatic check_result(input logic [LW-1:0] l, input logic [VW-1:0] v,
                                input logic [DW-1:0] d, input logic n);
        check("lit_label", {56'd0, out_label}, {56'd0, l});
        check("lit_votes", {61'd0, out_votes}, {61'd0, v});
        check("lit_dist",  {32'd0, out_dist},  {32'd0, d});
        check("lit_none",  {63'd0, out_none},  {63'd0, n});
    endtask

    task automatic check_all_zero();
        check("rst_in_ready",  {63'd0, in_ready},  64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_label",     {56'd0, out_label}, 64'd0);
        check("rst_votes",     {61'd0, out_votes}, 64'd0);
        check("rst_dist",      {32'd0, out_dist},  64'd0);
        check("rst_none",      {63'd0, out_none},  64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [DW-1:0] acc;
        rst            = 1'b0;
        in_valid       = 1'b0;
        out_ready      = 1'b0;
        neighbour_info = '0;

        // Reset state
        #2;
        check_all_zero();
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b1;
        check("in_ready_pre_edge", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        check("in_ready_post_rst", {63'd0, in_ready}, 64'd1);

        // Majority label 2 (entries listed index 3..0)
        labs = {8'd3, 8'd2, 8'd2, 8'd1};
        dsts = {32'd50, 32'd8, 32'd4, 32'd2};
        accept_list(); wait_result();
        check_result(8'd2, 3'd2, 32'd4, 1'b0);
        handshake();

        // Tie: nearest wins
        labs = {8'd2, 8'd1, 8'd2, 8'd1};
        dsts = {32'd50, 32'd8, 32'd4, 32'd2};
        accept_list(); wait_result();
        check_result(8'd1, 3'd2, 32'd2, 1'b0);
        handshake();

        // Empty entries 2 and 3
        labs = {8'd5, 8'd5, 8'd5, 8'd7};
        dsts = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd20, 32'd10};
        accept_list(); wait_result();
        check_result(8'd7, 3'd1, 32'd10, 1'b0);
        handshake();

        // All empty
        labs = {8'd9, 8'd9, 8'd9, 8'd9};
        dsts = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        accept_list(); wait_result();
        check_result(8'd0, 3'd0, 32'hFFFF_FFFF, 1'b1);
        handshake();

        // Unanimous label, all four vote
        labs = {8'd4, 8'd4, 8'd4, 8'd4};
        dsts = {32'd40, 32'd30, 32'd20, 32'd11};
        accept_list(); wait_result();
        check_result(8'd4, 3'd4, 32'd11, 1'b0);

        // Hold in DONE with input activity; comparator checks stability each cycle
        for (int c = 0; c < 6; c++) begin
            neighbour_info = {$urandom, $urandom, $urandom, $urandom, $urandom};
            in_valid       = c[0];
            @(posedge clk); #1;
            check("hold_in_ready",  {63'd0, in_ready},  64'd0);
            check("hold_out_valid", {63'd0, out_valid}, 64'd1);
            check("hold_label",     {56'd0, out_label}, 64'd4);
        end
        in_valid = 1'b0;
        handshake();

        // Reset during the 2nd COUNT cycle aborts the operation
        labs = {8'd3, 8'd3, 8'd1, 8'd1};
        dsts = {32'd9, 32'd7, 32'd5, 32'd3};
        accept_list();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        armed = 1'b0;
        check_all_zero();
        @(posedge clk); #3;
        rst = 1'b1;
        check("abort_in_ready_pre", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        check("abort_in_ready_post", {63'd0, in_ready}, 64'd1);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        check("abort_no_valid", {63'd0, seen}, 64'd0);

        // Next list after abort
        labs = {8'd6, 8'd8, 8'd6, 8'd8};
        dsts = {32'd90, 32'd70, 32'd33, 32'd21};
        accept_list(); wait_result();
        check_result(8'd8, 3'd2, 32'd21, 1'b0);
        handshake();

        // Model-checked lists, sorted distances with occasional empty tail
        for (int n = 0; n < 8; n++) begin
            acc = 32'd0;
            for (int i = 0; i < K; i++) begin
                acc     = acc + DW'($urandom_range(1, 100));
                labs[i] = LW'($urandom_range(0, 3));
                dsts[i] = acc;
            end
            if (n % 3 == 1) dsts[3] = 32'hFFFF_FFFF;
            if (n % 3 == 2) begin
                dsts[2] = 32'hFFFF_FFFF;
                dsts[3] = 32'hFFFF_FFFF;
            end
            accept_list(); wait_result();
            check("mdl_valid", {63'd0, out_valid}, 64'd1);
            handshake();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/knn_vote.md
KNN_VOTE -- requirements
Module: knn_vote

Interface
REQ-001 Parameter DATA_W, default 32: distance field width per neighbour entry.
REQ-002 Parameter LABEL_W, default 8: label field width per neighbour entry.
REQ-003 Parameter N_NEIGHBOUR, default 4: number of entries K in the neighbour list, 1 to 16.
REQ-004 The block SHALL have the following ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: neighbour list valid.
- in_ready, output, 1: block can accept a list.
- neighbour_info, input, (DATA_W+LABEL_W)*N_NEIGHBOUR: packed sorted neighbour list.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.
- out_label, output, LABEL_W: winning label.
- out_votes, output, clog2(N_NEIGHBOUR+1): vote count of the winner.
- out_dist, output, DATA_W: distance of the winner's nearest entry.
- out_none, output, 1: no valid entries were present.

Function
REQ-005 Entry i SHALL occupy bits [(i+1)*(DATA_W+LABEL_W)-1 : i*(DATA_W+LABEL_W)], packed {dist, label} with label in the low LABEL_W bits; entry 0 is the nearest.
REQ-006 An entry whose dist equals all-ones SHALL be treated as empty and SHALL neither vote nor win.
REQ-007 The FSM SHALL have states IDLE, COUNT and DONE; in_ready SHALL be 1 only in IDLE.
REQ-008 In IDLE, in_valid&in_ready SHALL register neighbour_info into an internal buffer, clear the index to 0, clear best votes to 0, and move to COUNT.
REQ-009 In COUNT, each cycle SHALL evaluate index i:
- votes(i) = number of non-empty entries j in 0..K-1 with label(j) == label(i).
- If entry i is non-empty and votes(i) > best votes, the best label, votes and dist SHALL update from entry i.
REQ-010 The comparison SHALL be strictly greater, so on a vote tie the lowest index (nearest) candidate wins.
REQ-011 After evaluating i = K-1, the FSM SHALL move to DONE, so out_valid rises exactly K+1 cycles after the accepting edge.
REQ-012 In DONE, out_valid SHALL be 1 and out_label, out_votes, out_dist and out_none SHALL be registered and held stable until out_ready is sampled high.
REQ-013 When out_valid&out_ready, the FSM SHALL return to IDLE, out_valid SHALL be 0 on the next cycle, and in_ready SHALL be 1 on that same next cycle; there is no same-cycle accept.
REQ-014 If all entries are empty, the result SHALL be out_none=1, out_label=0, out_votes=0, out_dist=all-ones.
REQ-015 in_valid and neighbour_info changes outside IDLE SHALL be ignored; the buffer SHALL isolate the input from the calculation in progress.
REQ-016 Vote arithmetic SHALL be unsigned, and the counter width SHALL hold K without overflow.

Reset
REQ-017 While rst=0, the state SHALL be IDLE and in_ready, out_valid, out_label, out_votes and out_none SHALL be 0; out_dist and the buffer SHALL be 0.
REQ-018 in_ready SHALL be registered: 0 during reset and 1 from the first rising clk edge after rst rises.
REQ-019 Reset asserted in COUNT or DONE SHALL abort the operation immediately and discard the partial result; no out_valid follows.

Verification (K=4, DATA_W=32, LABEL_W=8)
REQ-020 Input labels {1,2,2,3}, dists {2,4,8,50} -> out_label=2, out_votes=2, out_dist=4, out_none=0, with out_valid exactly 5 cycles after accept.
REQ-021 Tie case: labels {1,2,1,2}, dists {2,4,8,50} -> out_label=1, out_votes=2, out_dist=2.
REQ-022 Empty entries: entries 2 and 3 with dist=0xFFFFFFFF, labels {7,5,5,5} -> out_label=7, out_votes=1, out_dist=entry0 dist.
REQ-023 All four entries empty -> out_none=1, out_label=0, out_votes=0, out_dist=0xFFFFFFFF.
REQ-024 Hold out_ready=0 for 6 cycles in DONE while changing neighbour_info and pulsing in_valid -> outputs stay stable, in_ready=0; after the handshake, in_ready=1 next cycle.
REQ-025 Drive rst=0 in the 2nd COUNT cycle -> all outputs are 0 at once, in_ready=1 one cycle after release, and the next list gives a correct result.
